axo_csr_seq: RTL

- Multi-cycle sequencer for Zicsr instructions (CSRRW/S/C and their immediate forms).
- Takes a decoded CSR instruction from the core and drives a CSR read over the shared CSR bus, then computes the new value.
- Then drives the CSR write, then writes the old value back through the arbitrated register-file write port.
- Sits between the decode stage and the CSR bus / regfile write-port arbiter. Enforces the architectural read/write suppression and illegal-access rules.

---
 rtl/axo_csr_seq.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/axo_csr_seq.sv
// Zicsr sequencer: checks legality, reads the CSR, writes the updated value,
// then returns the old value through the arbitrated regfile write port.
//
// state | meaning
// IDLE  | ready for a new instruction
// CHECK | legality and read/write suppression decision
// READ  | CSR read outstanding
// WRITE | CSR write outstanding
// WB    | old value waiting for the regfile write port
// DONE  | one-cycle completion pulse
module axo_csr_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            ready,
  input  logic [2:0]      funct3,
  input  logic [11:0]     csr_addr,
  input  logic [4:0]      rs1,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [4:0]      rd,
  output logic            done,
  output logic            illegal,
  output logic            csr_re,
  output logic            csr_we,
  output logic [11:0]     csr_a,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            csr_ack,
  input  logic            csr_err,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_din,
  input  logic            rf_gnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_READ, S_WRITE, S_WB, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [11:0]       addr_q, addr_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [XLEN-1:0]   rs1_val_q, rs1_val_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic              ill_q, ill_d;

  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              csr_re_q, csr_re_d;
  logic              csr_we_q, csr_we_d;
  logic [11:0]       csr_a_q, csr_a_d;
  logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_din_q, rf_din_d;

  logic [XLEN-1:0]   bitmask;
  logic [XLEN-1:0]   wval;
  logic              do_write, do_read, bad;

  assign bitmask  = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_q} : rs1_val_q;
  assign do_write = (funct3_q[1:0] == 2'b01) | (rs1_q != 5'd0);
  assign do_read  = (funct3_q[1:0] != 2'b01) | (rd_q != 5'd0);
  assign bad      = (funct3_q[1:0] == 2'b00) | (do_write & (addr_q[11:10] == 2'b11));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      funct3_q    <= '0;
      addr_q      <= '0;
      rs1_q       <= '0;
      rs1_val_q   <= '0;
      rd_q        <= '0;
      old_q       <= '0;
      ill_q       <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      csr_re_q    <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_a_q     <= '0;
      csr_wdata_q <= '0;
      rf_we_q     <= 1'b0;
      rf_rd_q     <= '0;
      rf_din_q    <= '0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      rs1_q       <= rs1_d;
      rs1_val_q   <= rs1_val_d;
      rd_q        <= rd_d;
      old_q       <= old_d;
      ill_q       <= ill_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
      csr_re_q    <= csr_re_d;
      csr_we_q    <= csr_we_d;
      csr_a_q     <= csr_a_d;
      csr_wdata_q <= csr_wdata_d;
      rf_we_q     <= rf_we_d;
      rf_rd_q     <= rf_rd_d;
      rf_din_q    <= rf_din_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    rs1_d     = rs1_q;
    rs1_val_d = rs1_val_q;
    rd_d      = rd_q;
    old_d     = old_q;
    ill_d     = ill_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          funct3_d  = funct3;
          addr_d    = csr_addr;
          rs1_d     = rs1;
          rs1_val_d = rs1_val;
          rd_d      = rd;
          old_d     = '0;
          ill_d     = 1'b0;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad) begin
          ill_d   = 1'b1;
          state_d = S_DONE;
        end else if (do_read) begin
          state_d = S_READ;
        end else if (do_write) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_READ: begin
        if (csr_ack) begin
          if (csr_err) begin
            ill_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            old_d = csr_rdata;
            if (do_write)           state_d = S_WRITE;
            else if (rd_q != 5'd0)  state_d = S_WB;
            else                    state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        if (csr_ack) begin
          if (csr_err) begin
            ill_d   = 1'b1;
            state_d = S_DONE;
          end else if ((rd_q != 5'd0) && do_read) begin
            state_d = S_WB;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WB:    if (rf_gnt) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every request leaves a flop.
  always_comb begin
    case (funct3_q[1:0])
      2'b01:   wval = bitmask;
      2'b10:   wval = old_d | bitmask;
      2'b11:   wval = old_d & ~bitmask;
      default: wval = '0;
    endcase
    csr_re_d    = (state_d == S_READ);
    csr_we_d    = (state_d == S_WRITE);
    csr_a_d     = (csr_re_d || csr_we_d) ? addr_q : 12'd0;
    csr_wdata_d = csr_we_d ? wval : '0;
    rf_we_d     = (state_d == S_WB);
    rf_rd_d     = rf_we_d ? rd_q : 5'd0;
    rf_din_d    = rf_we_d ? old_d : '0;
    done_d      = (state_d == S_DONE);
    illegal_d   = done_d & ill_d;
  end

  assign ready     = (state_q == S_IDLE);
  assign done      = done_q;
  assign illegal   = illegal_q;
  assign csr_re    = csr_re_q;
  assign csr_we    = csr_we_q;
  assign csr_a     = csr_a_q;
  assign csr_wdata = csr_wdata_q;
  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_din    = rf_din_q;

endmodule
